instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Program writer for the instruction memory that the fetch unit reads.
- Accepts 64-bit instruction words from a host over a valid/ready stream.
- Serialises each word into DATA_WIDTH-wide bytes and writes them to DRAM at consecutive addresses starting at BASE_ADDR, in the byte order the fetch unit reassembles.
- Sits between the host/test harness and the DRAM write port; runs before the accelerator top is started.

Parameters:
- ADDR_WIDTH, 24, DRAM byte address width.
- DATA_WIDTH, 8, DRAM data width (one byte per write).
- INSTR_WIDTH, 64, instruction width; must be a multiple of DATA_WIDTH.
- BASE_ADDR, 0, first byte address of the program region.
- REGION_BYTES, 4096, size of the program region in bytes.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse; begins a new program load.
- in_valid  in  1  host instruction valid.
- in_ready  out  1  loader can accept an instruction.
- in_instr  in  INSTR_WIDTH  instruction word.
- in_last  in  1  marks the final instruction of the program (sampled with the handshake).
- mem_we  out  1  DRAM write request.
- mem_addr  out  ADDR_WIDTH  DRAM byte address.
- mem_wdata  out  DATA_WIDTH  DRAM write byte.
- mem_ready  in  1  DRAM accepts the write this cycle.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at the end of a load.
- error  out  1  sticky region-overflow flag; cleared by the next load_start.
- instr_count  out  16  instructions fully written in the current load.

Behaviour:
- Reset (rst_n=0, async): state L_IDLE. All outputs 0: in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, instr_count. Pointer and shift register are cleared.
- Reset mid-write: the write is abandoned immediately; no further mem_we occurs.
- States: L_IDLE, L_ACCEPT, L_WRITE, L_DONE.
- L_IDLE:
  - in_ready=0, busy=0.
  - On load_start: ptr<=BASE_ADDR, instr_count<=0, error<=0, go to L_ACCEPT.
- L_ACCEPT:
  - in_ready=1, busy=1.
  - On in_valid&&in_ready: latch in_instr into the shift register, latch in_last, byte_cnt<=0.
  - If ptr+INSTR_WIDTH/DATA_WIDTH > BASE_ADDR+REGION_BYTES: set error, discard the word, go to L_DONE.
  - Otherwise go to L_WRITE.
- L_WRITE:
  - in_ready=0, busy=1, mem_we=1, mem_addr=ptr, mem_wdata=shift[DATA_WIDTH-1:0].
  - On mem_ready: ptr++, shift>>=DATA_WIDTH, byte_cnt++.
  - When the final byte (byte_cnt==INSTR_WIDTH/DATA_WIDTH-1) is accepted: instr_count++, then go to L_DONE if in_last is latched, else to L_ACCEPT.
  - Without mem_ready, mem_addr and mem_wdata hold stable.
- L_DONE: done=1 for exactly one cycle, busy=1, then return to L_IDLE. error and instr_count hold until the next load_start.
- Byte order is little-endian: instr[7:0] goes to the lowest address, instr[63:56] to base+7.
- Timing:
  - mem_* outputs and in_ready are decoded from registered state only; there is no combinational path from mem_ready or in_valid.
  - With mem_ready tied high, each instruction costs 1 accept cycle + 8 write cycles.
- load_start while not in L_IDLE is ignored.
- in_valid in L_IDLE, L_WRITE or L_DONE is not accepted; the host must hold it.
- Address arithmetic is modulo 2^ADDR_WIDTH, but the overflow check prevents any write outside the region.
- An instruction with in_last=1 that overflows still ends the load with done and error both set.

Test Plan:
1. Single word: load_start, then 0x0123456789ABCDEF with in_last=1, mem_ready=1, BASE_ADDR=0 → writes EF,CD,AB,89,67,45,23,01 to addresses 0–7 on consecutive cycles. done pulses 1 cycle after the 8th write; instr_count=1; error=0.
2. Back-pressure: same word with mem_ready alternating 0/1 → 8 writes total; addr/data stable while mem_ready=0; no byte duplicated or skipped; done after the 8th accepted write.
3. Multi-word: three words 0x11…11, 0x22…22, 0x33…33 (last on third), host in_valid gapped → bytes 0x11 at 0–7, 0x22 at 8–15, 0x33 at 16–23. in_ready low during writes; instr_count=3.
4. Overflow: REGION_BYTES=16, BASE_ADDR=0x100, send three words → first two written to 0x100–0x10F. Third accepted but not written; error=1, done pulses, instr_count=2. Next load_start clears error.
5. Reset mid-load: assert rst_n=0 during the 4th byte of a word → all outputs 0 same cycle, state L_IDLE. A fresh load after release behaves as scenario 1.
6. Spurious start: load_start pulsed while in L_WRITE → ignored; ptr and instr_count unaffected; load completes normally.

Source files
------------

// File: rtl/instr_loader.sv
// Instruction-memory program writer.
// Serialises host instruction words into little-endian DRAM byte writes.
module instr_loader #(
  parameter int unsigned ADDR_WIDTH   = 24,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned INSTR_WIDTH  = 64,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned REGION_BYTES = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic                   in_last,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic                   mem_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [15:0]            instr_count
);

  localparam int unsigned BPW = INSTR_WIDTH / DATA_WIDTH;
  localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE =
    ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(BASE_ADDR + REGION_BYTES);
  localparam logic [ADDR_WIDTH:0] STEP =
    (ADDR_WIDTH+1)'(BPW);

  typedef enum logic [1:0] {
    L_IDLE,
    L_ACCEPT,
    L_WRITE,
    L_DONE
  } state_t;

  state_t                   state;
  state_t                   state_nx;
  logic [ADDR_WIDTH-1:0]    ptr;
  logic [INSTR_WIDTH-1:0]   shift;
  logic [CW-1:0]            byte_cnt;
  logic                     last_q;
  logic                     fire;
  logic                     ovf;
  logic                     byte_ok;
  logic                     final_byte;

  assign fire       = (state == L_ACCEPT) && in_valid;
  // one bit wider so a word ending past the region top cannot wrap
  assign ovf        = ({1'b0, ptr} + STEP) > LIMIT;
  assign byte_ok    = (state == L_WRITE) && mem_ready;
  assign final_byte = byte_ok && (byte_cnt == CW'(BPW - 1));

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      L_IDLE: begin
        if (load_start) state_nx = L_ACCEPT;
      end
      L_ACCEPT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nx = ovf ? L_DONE : L_WRITE;
      end
      L_WRITE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ptr;
        mem_wdata = shift[DATA_WIDTH-1:0];
        if (final_byte) state_nx = last_q ? L_DONE : L_ACCEPT;
      end
      L_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = L_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= L_IDLE;
      ptr         <= '0;
      shift       <= '0;
      byte_cnt    <= '0;
      last_q      <= 1'b0;
      error       <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nx;
      if ((state == L_IDLE) && load_start) begin
        ptr         <= BASE;
        instr_count <= '0;
        error       <= 1'b0;
      end
      if (fire) begin
        shift    <= in_instr;
        last_q   <= in_last;
        byte_cnt <= '0;
        if (ovf) error <= 1'b1;
      end
      if (byte_ok) begin
        ptr      <= ptr + ADDR_WIDTH'(1);
        shift    <= shift >> DATA_WIDTH;
        byte_cnt <= byte_cnt + CW'(1);
        if (final_byte) instr_count <= instr_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: default region instance plus a small
// region at 0x100 for overflow; byte writes checked via a queue.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic        in_valid;
  logic [63:0] in_instr;
  logic        in_last;
  logic        mem_ready;
  logic        sel;
  logic        bp;

  logic        r0, r1, we0, we1, b0, b1, d0, d1, e0, e1;
  logic [23:0] a0, a1;
  logic [7:0]  w0, w1;
  logic [15:0] c0, c1;

  logic        in_ready, mem_we, busy, done, error;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [15:0] instr_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_wr = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_loader u_dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start & ~sel),
    .in_valid(in_valid), .in_ready(r0),
    .in_instr(in_instr), .in_last(in_last),
    .mem_we(we0), .mem_addr(a0), .mem_wdata(w0),
    .mem_ready(mem_ready), .busy(b0), .done(d0),
    .error(e0), .instr_count(c0)
  );

  instr_loader #(
    .BASE_ADDR(32'h100), .REGION_BYTES(16)
  ) u_ovf (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start & sel),
    .in_valid(in_valid), .in_ready(r1),
    .in_instr(in_instr), .in_last(in_last),
    .mem_we(we1), .mem_addr(a1), .mem_wdata(w1),
    .mem_ready(mem_ready), .busy(b1), .done(d1),
    .error(e1), .instr_count(c1)
  );

  assign in_ready    = sel ? r1 : r0;
  assign mem_we      = sel ? we1 : we0;
  assign mem_addr    = sel ? a1 : a0;
  assign mem_wdata   = sel ? w1 : w0;
  assign busy        = sel ? b1 : b0;
  assign done        = sel ? d1 : d0;
  assign error       = sel ? e1 : e0;
  assign instr_count = sel ? c1 : c0;

  typedef struct packed {
    logic            sel;
    logic            bp;
    logic [3:0]      gap;
    logic [1:0]      n;
    logic            spur;
    logic [2:0][63:0] w;
    logic [15:0]     cnt;
    logic            err;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = bp ? ~mem_ready : 1'b1;
    end
  end

  // write monitor: pops the expected {addr,data} on each accepted byte
  initial begin
    logic        hold_v;
    logic [23:0] hold_a;
    logic [7:0]  hold_d;
    logic [31:0] item;
    hold_v = 1'b0;
    hold_a = '0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_we) begin
        chk("rdy_in_write", in_ready, 0);
        if (hold_v) begin
          chk("hold_addr", mem_addr, hold_a);
          chk("hold_data", mem_wdata, hold_d);
        end
        if (mem_ready) begin
          hold_v  = 1'b0;
          last_wr = cyc;
          item = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
          chk("wr", {mem_addr, mem_wdata}, item);
        end else begin
          hold_v = 1'b1;
          hold_a = mem_addr;
          hold_d = mem_wdata;
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  task automatic send(input logic [63:0] w, input logic last,
                      output int hc);
    bit ok = 0;
    in_valid = 1'b1;
    in_instr = w;
    in_last  = last;
    for (int c = 0; c < 200; c++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_seen", ok, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hc = cyc;
  endtask

  task automatic wait_done(output int dc);
    bit ok = 0;
    dc = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        dc = cyc;
        break;
      end
    end
    chk("done_seen", ok, 1);
  endtask

  task automatic run(input int k);
    vec_t v;
    int   base, lim, ptr, hc, h0, dc;
    bit   ovf;
    v    = tbl[k];
    sel  = v.sel;
    bp   = v.bp;
    base = v.sel ? 32'h100 : 0;
    lim  = v.sel ? base + 16 : base + 4096;
    ptr  = base;
    ovf  = 0;
    h0   = 0;
    @(posedge clk);
    #1;
    pulse_start();
    @(negedge clk);
    chk($sformatf("v%0d_start_busy", k), busy, 1);
    chk($sformatf("v%0d_start_err", k), error, 0);
    chk($sformatf("v%0d_start_cnt", k), instr_count, 0);
    for (int i = 0; i < int'(v.n); i++) begin
      if (i > 0 && v.gap > 0) begin
        repeat (int'(v.gap)) @(posedge clk);
        #1;
      end
      ovf = (ptr + 8) > lim;
      send(v.w[i], i == int'(v.n) - 1, hc);
      if (i == 0) h0 = hc;
      if (ovf) break;
      for (int b = 0; b < 8; b++) begin
        logic [63:0] sh;
        sh = v.w[i] >> (8 * b);
        exp_q.push_back({24'(ptr + b), sh[7:0]});
      end
      ptr += 8;
      if (v.spur && i == 0) pulse_start();
    end
    wait_done(dc);
    chk($sformatf("v%0d_cnt", k), instr_count, v.cnt);
    chk($sformatf("v%0d_err", k), error, v.err);
    chk($sformatf("v%0d_busy", k), busy, 1);
    chk($sformatf("v%0d_q_left", k), exp_q.size(), 0);
    if (!ovf) chk($sformatf("v%0d_done_lat", k), dc, last_wr + 1);
    if (!v.bp && v.n == 1)
      chk($sformatf("v%0d_first_lat", k), dc - h0, 8);
    @(negedge clk);
    chk($sformatf("v%0d_done_1cyc", k), done, 0);
    chk($sformatf("v%0d_idle", k), busy, 0);
    chk($sformatf("v%0d_err_hold", k), error, v.err);
    chk($sformatf("v%0d_cnt_hold", k), instr_count, v.cnt);
  endtask

  initial begin
    bit ok;
    tbl[0] = '{sel:0, bp:0, gap:0, n:1, spur:0,
               w:{64'h0, 64'h0, 64'h0123456789ABCDEF}, cnt:1, err:0};
    tbl[1] = '{sel:0, bp:1, gap:0, n:1, spur:0,
               w:{64'h0, 64'h0, 64'h0123456789ABCDEF}, cnt:1, err:0};
    tbl[2] = '{sel:0, bp:0, gap:3, n:3, spur:0,
               w:{64'h3333333333333333, 64'h2222222222222222,
                  64'h1111111111111111}, cnt:3, err:0};
    tbl[3] = '{sel:1, bp:0, gap:0, n:3, spur:0,
               w:{64'hFEDCBA9876543210, 64'h5A5A5A5A00FF00FF,
                  64'hA5A5A5A5C3C3C3C3}, cnt:2, err:1};
    tbl[4] = '{sel:1, bp:1, gap:1, n:2, spur:0,
               w:{64'h0, {$urandom, $urandom}, {$urandom, $urandom}},
               cnt:2, err:0};
    tbl[5] = '{sel:0, bp:0, gap:0, n:2, spur:1,
               w:{64'h0, 64'h8877665544332211, 64'hDEADBEEFCAFEF00D},
               cnt:2, err:0};

    rst_n = 1'b0;
    load_start = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_last = 1'b0;
    sel = 1'b0;
    bp = 1'b0;
    #23;
    chk("rst_outs0", {r0, we0, a0, w0, b0, d0, e0, c0}, 0);
    chk("rst_outs1", {r1, we1, a1, w1, b1, d1, e1, c1}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) run(k);

    // reset while the fourth byte is on the bus
    sel = 1'b0;
    bp  = 1'b0;
    @(posedge clk);
    #1;
    pulse_start();
    begin
      int hc;
      logic [63:0] w;
      w = 64'h0123456789ABCDEF;
      send(w, 1'b1, hc);
      for (int b = 0; b < 8; b++) begin
        logic [63:0] sh;
        sh = w >> (8 * b);
        exp_q.push_back({24'(b), sh[7:0]});
      end
    end
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (mem_we && mem_addr == 24'd3) begin
        ok = 1;
        break;
      end
    end
    chk("rst_byte4_seen", ok, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {in_ready, mem_we, mem_addr, mem_wdata,
                        busy, done, error, instr_count}, 0);
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_no_we", mem_we, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
